// File: rtl/bus_tap_pkg.sv
// Shared types for the bus write tap: record modes, serializer states and
// the FIFO entry layout.
package bus_tap_pkg;

    localparam int MODE_DATA      = 0;
    localparam int MODE_ADDR_DATA = 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    typedef struct packed {
        logic [7:0] addr8;
        logic [7:0] data8;
    } fifo_entry_t;

endpackage

// File: rtl/tap_uart_tx.sv
// 8N1 byte serializer with a valid/ready byte input. The input is ready while
// idle and on the last clk of a stop bit, so a second byte can follow with no
// idle gap. Every state lasts exactly BAUD_DIV clks.
module tap_uart_tx
    import bus_tap_pkg::*;
#(
    parameter int BAUD_DIV = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       idle,
    output logic       txd
);

    localparam int CNT_W = $clog2(BAUD_DIV);

    tx_state_t        state;
    tx_state_t        state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_p0;
    logic             tick;
    logic             load;

    assign tick       = (baud_cnt == CNT_W'(BAUD_DIV - 1));
    assign byte_ready = (state == IDLE) || ((state == STOP) && tick);
    assign load       = byte_valid && byte_ready;
    assign idle       = (state == IDLE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: advance on the last clk of each bit period
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (load) state_nxt = START;
            START: if (tick) state_nxt = DATA;
            DATA:  if (tick && (bit_cnt == 3'd7)) state_nxt = STOP;
            STOP:  if (tick) state_nxt = load ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Baud and data-bit counters; baud counter rests at zero while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (state == IDLE || tick) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (state == START) begin
                bit_cnt <= '0;
            end else if (state == DATA && tick) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Shift register: loaded on accept, shifted right after each data bit
    always_ff @(posedge clk) begin
        if (load) begin
            shift_p0 <= byte_data;
        end else if (state == DATA && tick) begin
            shift_p0 <= {1'b0, shift_p0[7:1]};
        end
    end

    // Line level follows the state; idle and stop are marking
    always_comb begin
        txd = 1'b1;
        case (state)
            IDLE:    txd = 1'b1;
            START:   txd = 1'b0;
            DATA:    txd = shift_p0[0];
            STOP:    txd = 1'b1;
            default: txd = 1'b1;
        endcase
    end

endmodule

// File: rtl/bus_write_tap.sv
// Passive 65C02 bus tap: captures CPU writes that land in an address window,
// queues them in a FIFO and replays them on an 8N1 serial line, either as the
// data byte alone or as an address-low/data byte pair.
module bus_write_tap
    import bus_tap_pkg::*;
#(
    parameter logic [15:0] ADDR_BASE = 16'h8000,
    parameter int          WIN_SIZE  = 4,
    parameter int          DEPTH     = 16,
    parameter int          BAUD_DIV  = 87,
    parameter int          MODE      = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [15:0]                  address,
    input  logic [7:0]                   data_in,
    input  logic                         rwb,
    input  logic                         phi2,
    input  logic                         enable,
    output logic                         txd,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [7:0]                   dropped
);

    localparam int          PTR_W    = $clog2(DEPTH);
    localparam int          LVL_W    = $clog2(DEPTH + 1);
    localparam logic [15:0] WIN_MASK = ~(16'(WIN_SIZE - 1));

    logic              phi2_p0;
    logic              rwb_p0;
    logic [15:0]       addr_p0;
    logic [7:0]        data_p0;
    logic              strobe;
    logic              push_req;
    logic              push_ok;
    logic              pop;

    fifo_entry_t       mem [DEPTH];
    fifo_entry_t       head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;

    logic              pending;
    logic [7:0]        second_p0;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_idle;
    logic [7:0]        tx_byte;

    // Bus capture stage: the strobe is the first clk after phi2 falls
    assign strobe   = !phi2 && phi2_p0;
    assign push_req = strobe && !rwb_p0 && ((addr_p0 & WIN_MASK) == ADDR_BASE) && enable;

    // Registered phi2 and rwb (control path)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phi2_p0 <= 1'b0;
            rwb_p0  <= 1'b1;
        end else begin
            phi2_p0 <= phi2;
            if (phi2) begin
                rwb_p0 <= rwb;
            end
        end
    end

    // Registered address and data, tracked while phi2 is high
    always_ff @(posedge clk) begin
        if (phi2) begin
            addr_p0 <= address;
            data_p0 <= data_in;
        end
    end

    // FIFO stage: a full FIFO still accepts a push when a pop frees a slot
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push_req && (!full || pop);
    assign head    = mem[rd_ptr];

    // Entry storage, written at the strobe edge
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= '{addr8: addr_p0[7:0], data8: data_p0};
        end
    end

    // Pointers, occupancy and saturating drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            dropped <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push_req && full && !pop && (dropped != 8'hFF)) begin
                dropped <= dropped + 8'd1;
            end
        end
    end

    // Sequencer stage: pop only from an idle serializer; a pending second
    // byte is handed over at the end of the first byte's stop bit
    assign pop      = !pending && !empty && tx_idle;
    assign tx_valid = pending || pop;
    assign tx_byte  = pending ? second_p0 :
                      ((MODE == MODE_ADDR_DATA) ? head.addr8 : head.data8);

    // Pending flag for the data byte of a two-byte record
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (pop && (MODE == MODE_ADDR_DATA)) begin
            pending <= 1'b1;
        end else if (pending && tx_ready) begin
            pending <= 1'b0;
        end
    end

    // Data byte held for the second half of a two-byte record
    always_ff @(posedge clk) begin
        if (pop) begin
            second_p0 <= head.data8;
        end
    end

    tap_uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk        (clk),
        .reset      (reset),
        .byte_data  (tx_byte),
        .byte_valid (tx_valid),
        .byte_ready (tx_ready),
        .idle       (tx_idle),
        .txd        (txd)
    );

    assign busy       = !empty || !tx_idle || pending;
    assign fifo_level = level;

endmodule

// File: tb/tb_bus_write_tap.sv
// Scoreboard bench for bus_write_tap. Three instances share one bus:
// u0 MODE 0 at BAUD_DIV 87, u1 MODE 1 at BAUD_DIV 8, u2 MODE 0 with DEPTH 4
// and BAUD_DIV 4. Per-instance enables select which one captures.
module tb_bus_write_tap;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic        rwb;
    logic        phi2;
    logic        en0, en1, en2;

    logic        txd0, txd1, txd2;
    logic        busy0, busy1, busy2;
    logic [4:0]  level0, level1;
    logic [2:0]  level2;
    logic [7:0]  dropped0, dropped1, dropped2;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [7:0]  q2[$];
    bit          ign2 = 1'b0;
    bit          peak_clr = 1'b1;
    int          peak0 = 0;
    int          peak2 = 0;

    always #5 clk = ~clk;

    bus_write_tap u0 (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in), .rwb(rwb),
        .phi2(phi2), .enable(en0), .txd(txd0), .busy(busy0), .fifo_level(level0),
        .dropped(dropped0)
    );

    bus_write_tap #(.BAUD_DIV(8), .MODE(1)) u1 (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in), .rwb(rwb),
        .phi2(phi2), .enable(en1), .txd(txd1), .busy(busy1), .fifo_level(level1),
        .dropped(dropped1)
    );

    bus_write_tap #(.DEPTH(4), .BAUD_DIV(4)) u2 (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in), .rwb(rwb),
        .phi2(phi2), .enable(en2), .txd(txd2), .busy(busy2), .fifo_level(level2),
        .dropped(dropped2)
    );

    always @(negedge clk) begin
        if (peak_clr) begin
            peak0 <= 0;
            peak2 <= 0;
        end else begin
            if (int'(level0) > peak0) peak0 <= int'(level0);
            if (int'(level2) > peak2) peak2 <= int'(level2);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_txd(input int k);
        case (k)
            0:       return txd0;
            1:       return txd1;
            default: return txd2;
        endcase
    endfunction

    function automatic logic get_busy(input int k);
        case (k)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic wait_neg(input int n, inout bit aborted);
        repeat (n) begin
            @(negedge clk);
            if (reset) aborted = 1'b1;
        end
    endtask

    // Receive one 8N1 frame, sampling each bit near its middle
    task automatic rx_frame(input int k, input int baud, output logic [7:0] b, output bit aborted);
        logic st;
        aborted = 1'b0;
        b = 8'h00;
        @(negedge clk);
        while (get_txd(k) !== 1'b0) @(negedge clk);
        wait_neg(baud / 2, aborted);
        st = get_txd(k);
        for (int i = 0; i < 8; i++) begin
            wait_neg(baud, aborted);
            b[i] = get_txd(k);
        end
        wait_neg(baud, aborted);
        if (!aborted) begin
            check($sformatf("start_bit_u%0d", k), {31'd0, st}, 32'd0);
            check($sformatf("stop_bit_u%0d", k), {31'd0, get_txd(k)}, 32'd1);
        end
    endtask

    task automatic monitor(input int k, input int baud);
        logic [7:0] b;
        logic [7:0] e;
        bit         aborted;
        bit         have;
        forever begin
            rx_frame(k, baud, b, aborted);
            if (!aborted && !(k == 2 && ign2)) begin
                have = 1'b0;
                e = 8'h00;
                case (k)
                    0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
                    1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
                    default: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
                endcase
                if (have) begin
                    check($sformatf("rx_byte_u%0d", k), {24'd0, b}, {24'd0, e});
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte_u%0d: got %0h expected no frame at %0t", k, b, $time);
                end
            end
        end
    endtask

    initial monitor(0, 87);
    initial monitor(1, 8);
    initial monitor(2, 4);

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // One 6-clk CPU bus cycle; entered and left 1 time unit after a posedge.
    // The strobe falls on the posedge right after the task returns.
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic r);
        address = a;
        data_in = d;
        rwb     = r;
        phi2    = 1'b0;
        repeat (3) @(posedge clk);
        #1 phi2 = 1'b1;
        repeat (3) @(posedge clk);
        #1 phi2 = 1'b0;
        rwb = 1'b1;
    endtask

    task automatic measure_busy(input int k, output int len);
        int n;
        n = 0;
        len = 0;
        do begin
            @(negedge clk);
            n++;
        end while (get_busy(k) !== 1'b1 && n < 20);
        if (get_busy(k) !== 1'b1) begin
            check($sformatf("busy_rise_u%0d", k), 32'd0, 32'd1);
            return;
        end
        while (get_busy(k) === 1'b1 && len < 5000) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int k, input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while ((get_busy(k) !== 1'b0 || q_size(k) != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) begin
            check($sformatf("drain_timeout_u%0d", k), 32'd0, 32'd1);
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int len;
        int lows;
        reset   = 1'b1;
        phi2    = 1'b0;
        rwb     = 1'b1;
        address = 16'h0000;
        data_in = 8'h00;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", {31'd0, txd0}, 32'd1);
        check("reset_busy", {31'd0, busy0}, 32'd0);
        check("reset_level", {27'd0, level0}, 32'd0);
        check("reset_dropped", {24'd0, dropped0}, 32'd0);
        reset = 1'b0;
        peak_clr = 1'b0;

        // MODE 0 single write of 8'h41
        en0 = 1'b1;
        q0.push_back(8'h41);
        sync();
        bus_cycle(16'h8000, 8'h41, 1'b0);
        measure_busy(0, len);
        check("m0_busy_len", len, 32'd871);
        wait_idle(0, 2000);
        check("m0_idle_busy", {31'd0, busy0}, 32'd0);
        check("m0_idle_txd", {31'd0, txd0}, 32'd1);

        // Window edges and a read inside the window
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        q0.push_back(8'h77);
        sync();
        bus_cycle(16'h7FFF, 8'h11, 1'b0);
        bus_cycle(16'h8003, 8'h77, 1'b0);
        bus_cycle(16'h8004, 8'h22, 1'b0);
        bus_cycle(16'h8001, 8'h33, 1'b1);
        wait_idle(0, 3000);
        check("win_peak", peak0, 32'd1);
        check("win_dropped", {24'd0, dropped0}, 32'd0);

        // Enable low suppresses capture
        en0 = 1'b0;
        sync();
        bus_cycle(16'h8000, 8'h55, 1'b0);
        repeat (5) @(negedge clk);
        check("en_off_level", {27'd0, level0}, 32'd0);
        check("en_off_busy", {31'd0, busy0}, 32'd0);

        // MODE 1 record: address low byte then data, back to back
        en1 = 1'b1;
        q1.push_back(8'h02);
        q1.push_back(8'h5A);
        sync();
        bus_cycle(16'h8002, 8'h5A, 1'b0);
        measure_busy(1, len);
        check("m1_busy_len", len, 32'd161);
        wait_idle(1, 500);
        en1 = 1'b0;

        // Overflow on DEPTH 4: writes 5, 6, 8, 9 are dropped; write 7 lands
        // on the same edge as a pop and is kept
        en2 = 1'b1;
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        q2.push_back(8'hA0);
        q2.push_back(8'hA1);
        q2.push_back(8'hA2);
        q2.push_back(8'hA3);
        q2.push_back(8'hA4);
        q2.push_back(8'hA7);
        sync();
        for (int i = 0; i < 10; i++) begin
            bus_cycle(16'h8000 + 16'(i % 4), 8'hA0 + 8'(i), 1'b0);
        end
        repeat (2) @(negedge clk);
        check("ovf_dropped", {24'd0, dropped2}, 32'd4);
        wait_idle(2, 2000);
        check("ovf_peak", peak2, 32'd4);

        // Drop counter saturation
        ign2 = 1'b1;
        sync();
        for (int i = 0; i < 400; i++) begin
            bus_cycle(16'h8001, 8'hC3, 1'b0);
        end
        repeat (2) @(negedge clk);
        check("sat_dropped", {24'd0, dropped2}, 32'd255);
        sync();
        for (int i = 0; i < 20; i++) begin
            bus_cycle(16'h8001, 8'hC3, 1'b0);
        end
        repeat (2) @(negedge clk);
        check("sat_hold", {24'd0, dropped2}, 32'd255);
        check("sat_full", {29'd0, level2}, 32'd4);
        en2 = 1'b0;
        sync();
        reset = 1'b1;
        q2.delete();
        #1;
        check("sat_rst_dropped", {24'd0, dropped2}, 32'd0);
        check("sat_rst_level", {29'd0, level2}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        ign2 = 1'b0;

        // Reset during the 4th data bit with 3 entries queued
        en0 = 1'b1;
        sync();
        bus_cycle(16'h8000, 8'h91, 1'b0);
        bus_cycle(16'h8001, 8'h92, 1'b0);
        bus_cycle(16'h8002, 8'h93, 1'b0);
        bus_cycle(16'h8003, 8'h94, 1'b0);
        repeat (2 + 4 * 87 - 18 + 40) @(posedge clk);
        #1;
        check("mid_level_before", {27'd0, level0}, 32'd3);
        reset = 1'b1;
        #1;
        check("mid_rst_txd", {31'd0, txd0}, 32'd1);
        check("mid_rst_level", {27'd0, level0}, 32'd0);
        check("mid_rst_busy", {31'd0, busy0}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (txd0 !== 1'b1 || busy0 !== 1'b0) lows++;
        end
        check("mid_no_residual", lows, 32'd0);
        q0.push_back(8'h3C);
        sync();
        bus_cycle(16'h8001, 8'h3C, 1'b0);
        wait_idle(0, 2000);

        // Everything expected was received
        check("end_q0", q0.size(), 32'd0);
        check("end_q1", q1.size(), 32'd0);
        check("end_q2", q2.size(), 32'd0);
        check("end_u1_idle", {26'd0, level1, busy1}, 32'd0);
        check("end_u1_dropped", {24'd0, dropped1}, 32'd0);
        check("end_u2_idle", {30'd0, txd2, busy2}, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
